// File: rtl/lsu_sram_bridge.sv
// lsu_sram_bridge: M-stage load/store unit driving a handshaked SRAM-like
// data port. Decodes MIPS load/store opcodes, flags misaligned accesses,
// issues one request per memory instruction and stalls the pipeline until
// the response returns, then delivers sign/zero-extended load data.
module lsu_sram_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mem_valid_i,
  input  logic [5:0]          op_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [31:0]         wdata_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                done_o,
  output logic [31:0]         rdata_o,
  output logic                addr_err_load_o,
  output logic                addr_err_store_o,
  output logic [ADDR_W-1:0]   badvaddr_o,
  output logic                data_req_o,
  output logic                data_wr_o,
  output logic [1:0]          data_size_o,
  output logic [ADDR_W-1:0]   data_addr_o,
  output logic [DATA_W/8-1:0] data_wstrb_o,
  output logic [DATA_W-1:0]   data_wdata_o,
  input  logic                data_addr_ok_i,
  input  logic                data_data_ok_i,
  input  logic [DATA_W-1:0]   data_rdata_i
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t             state;
  logic [5:0]         op_q;
  logic [OFF_W-1:0]   off_q;

  logic               is_load;
  logic               is_store;
  logic [1:0]         size_c;
  logic               misaligned;
  logic               legal_op;
  logic [OFF_W-1:0]   off_c;
  logic [NB-1:0]      base_mask;
  logic [NB-1:0]      wstrb_c;
  logic [DATA_W-1:0]  wdata_c;
  logic [31:0]        lane;
  logic [31:0]        ext_c;

  assign off_c = addr_i[OFF_W-1:0];

  // Opcode decode into load/store class and access size, plus alignment check
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size_c   = 2'd0;
    case (op_i)
      OP_LB, OP_LBU: begin is_load  = 1'b1; size_c = 2'd0; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; size_c = 2'd1; end
      OP_LW:         begin is_load  = 1'b1; size_c = 2'd2; end
      OP_SB:         begin is_store = 1'b1; size_c = 2'd0; end
      OP_SH:         begin is_store = 1'b1; size_c = 2'd1; end
      OP_SW:         begin is_store = 1'b1; size_c = 2'd2; end
      default:       begin is_load  = 1'b0; is_store = 1'b0; end
    endcase
    misaligned = ((size_c == 2'd2) && (addr_i[1:0] != 2'b00)) ||
                 ((size_c == 2'd1) && addr_i[0]);
    legal_op   = (is_load || is_store) && !misaligned;
  end

  // Byte-lane strobes and bus-wide replicated store data for the current op
  always_comb begin
    base_mask = '0;
    case (size_c)
      2'd0:    base_mask[0]   = 1'b1;
      2'd1:    base_mask[1:0] = 2'b11;
      default: base_mask[3:0] = 4'hF;
    endcase
    wstrb_c = is_store ? (base_mask << off_c) : '0;
    wdata_c = '0;
    if (is_store) begin
      case (size_c)
        2'd0:    wdata_c = {NB{wdata_i[7:0]}};
        2'd1:    wdata_c = {(NB/2){wdata_i[15:0]}};
        default: wdata_c = {(NB/4){wdata_i}};
      endcase
    end
  end

  // Select the addressed lane of the response and extend it per the captured op
  always_comb begin
    lane  = 32'(data_rdata_i >> {off_q, 3'b000});
    ext_c = lane;
    case (op_q)
      OP_LB:   ext_c = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  ext_c = {24'd0, lane[7:0]};
      OP_LH:   ext_c = {{16{lane[15]}}, lane[15:0]};
      OP_LHU:  ext_c = {16'd0, lane[15:0]};
      default: ext_c = lane;
    endcase
  end

  // Request FSM: capture the access, hold it on the port, track flushes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      op_q         <= '0;
      off_q        <= '0;
      data_wr_o    <= 1'b0;
      data_size_o  <= 2'd0;
      data_addr_o  <= '0;
      data_wstrb_o <= '0;
      data_wdata_o <= '0;
      rdata_o      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_valid_i && legal_op && !flush_i) begin
            op_q         <= op_i;
            off_q        <= off_c;
            data_wr_o    <= is_store;
            data_size_o  <= size_c;
            data_addr_o  <= addr_i;
            data_wstrb_o <= wstrb_c;
            data_wdata_o <= wdata_c;
            state        <= S_REQ;
          end
        end
        S_REQ: begin
          if (data_addr_ok_i)
            state <= flush_i ? S_DRAIN : S_WAIT;
          else if (flush_i)
            state <= S_IDLE;
        end
        S_WAIT: begin
          if (flush_i)
            state <= data_data_ok_i ? S_IDLE : S_DRAIN;
          else if (data_data_ok_i) begin
            rdata_o <= ext_c;
            state   <= S_RESP;
          end
        end
        S_DRAIN: begin
          if (data_data_ok_i)
            state <= S_IDLE;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign data_req_o = (state == S_REQ);
  assign done_o     = (state == S_RESP) && !flush_i;

  // Stall while a request is outstanding, or while a legal op waits in IDLE;
  // everything combinational reads zero while reset is held
  assign stall_o = resetn &&
                   ((state == S_REQ) || (state == S_WAIT) || (state == S_DRAIN) ||
                    (mem_valid_i && legal_op && !flush_i && (state != S_RESP)));

  assign addr_err_load_o  = resetn && is_load  && misaligned;
  assign addr_err_store_o = resetn && is_store && misaligned;
  assign badvaddr_o       = (addr_err_load_o || addr_err_store_o) ? addr_i : '0;

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// tb_lsu_sram_bridge: directed checks of lsu_sram_bridge with a 64-bit and a
// 32-bit data bus instance driven from the same pipeline/handshake inputs.
module tb_lsu_sram_bridge;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        addr_ok;
  logic        data_ok;
  logic [63:0] rdata64;
  logic [31:0] rdata32;

  logic        s64_stall, s64_done, s64_err_ld, s64_err_st, s64_req, s64_wr;
  logic [31:0] s64_rdata, s64_badva, s64_addr;
  logic [1:0]  s64_size;
  logic [7:0]  s64_wstrb;
  logic [63:0] s64_wdata;

  logic        s32_stall, s32_done, s32_err_ld, s32_err_st, s32_req, s32_wr;
  logic [31:0] s32_rdata, s32_badva, s32_addr;
  logic [1:0]  s32_size;
  logic [3:0]  s32_wstrb;
  logic [31:0] s32_wdata;

  int num_asserts = 0;
  int num_fails   = 0;

  lsu_sram_bridge #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .resetn(resetn), .mem_valid_i(mem_valid), .op_i(op),
    .addr_i(addr), .wdata_i(wdata), .flush_i(flush),
    .stall_o(s64_stall), .done_o(s64_done), .rdata_o(s64_rdata),
    .addr_err_load_o(s64_err_ld), .addr_err_store_o(s64_err_st),
    .badvaddr_o(s64_badva), .data_req_o(s64_req), .data_wr_o(s64_wr),
    .data_size_o(s64_size), .data_addr_o(s64_addr), .data_wstrb_o(s64_wstrb),
    .data_wdata_o(s64_wdata), .data_addr_ok_i(addr_ok),
    .data_data_ok_i(data_ok), .data_rdata_i(rdata64)
  );

  lsu_sram_bridge #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .resetn(resetn), .mem_valid_i(mem_valid), .op_i(op),
    .addr_i(addr), .wdata_i(wdata), .flush_i(flush),
    .stall_o(s32_stall), .done_o(s32_done), .rdata_o(s32_rdata),
    .addr_err_load_o(s32_err_ld), .addr_err_store_o(s32_err_st),
    .badvaddr_o(s32_badva), .data_req_o(s32_req), .data_wr_o(s32_wr),
    .data_size_o(s32_size), .data_addr_o(s32_addr), .data_wstrb_o(s32_wstrb),
    .data_wdata_o(s32_wdata), .data_addr_ok_i(addr_ok),
    .data_data_ok_i(data_ok), .data_rdata_i(rdata32)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, then settle before checks
  task automatic applyStimulus(input logic v, input logic [5:0] o,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic fl, input logic aok, input logic dok);
    @(negedge clk);
    mem_valid = v;
    op        = o;
    addr      = a;
    wdata     = wd;
    flush     = fl;
    addr_ok   = aok;
    data_ok   = dok;
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    num_asserts++;
    assert (observed === expected) else begin
      num_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Directed test sequence
  initial begin
    resetn = 1'b0; mem_valid = 1'b0; op = 6'd0; addr = 32'd0; wdata = 32'd0;
    flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata64 = 64'd0; rdata32 = 32'd0;

    // Reset state
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_stall", s64_stall, 0);
    checkOutput("rst_req",   s64_req,   0);
    checkOutput("rst_done",  s64_done,  0);
    checkOutput("rst_rdata", s64_rdata, 0);
    checkOutput("rst_wstrb", s64_wstrb, 0);
    resetn = 1'b1;

    // LW at 0x1000_0004, immediate handshakes
    $display("[TB] LW 64-bit lane 4");
    rdata64 = 64'h8765_4321_1234_5678;
    rdata32 = 32'h1234_5678;
    applyStimulus(1'b1, OP_LW, 32'h1000_0004, 32'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("lw_c0_stall", s64_stall, 1);
    checkOutput("lw_c0_req",   s64_req,   0);
    applyStimulus(1'b1, OP_LW, 32'h1000_0004, 32'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("lw_c1_req",   s64_req,   1);
    checkOutput("lw_c1_wr",    s64_wr,    0);
    checkOutput("lw_c1_size",  s64_size,  2);
    checkOutput("lw_c1_wstrb", s64_wstrb, 8'h00);
    checkOutput("lw_c1_addr",  s64_addr,  32'h1000_0004);
    applyStimulus(1'b1, OP_LW, 32'h1000_0004, 32'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("lw_c2_stall", s64_stall, 1);
    checkOutput("lw_c2_done",  s64_done,  0);
    applyStimulus(1'b1, OP_LW, 32'h1000_0004, 32'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("lw_c3_done",    s64_done,  1);
    checkOutput("lw_c3_rdata",   s64_rdata, 32'h8765_4321);
    checkOutput("lw_c3_stall",   s64_stall, 0);
    checkOutput("lw_c3_rdata32", s32_rdata, 32'h1234_5678);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("lw_c4_done", s64_done, 0);

    // SB at 0x03 with data 0xAB
    $display("[TB] SB lane 3");
    applyStimulus(1'b1, OP_SB, 32'h0000_0003, 32'h0000_00AB, 1'b0, 1'b1, 1'b1);
    checkOutput("sb_c0_stall", s32_stall, 1);
    applyStimulus(1'b1, OP_SB, 32'h0000_0003, 32'h0000_00AB, 1'b0, 1'b1, 1'b1);
    checkOutput("sb_c1_req",     s32_req,   1);
    checkOutput("sb_c1_wr",      s32_wr,    1);
    checkOutput("sb_c1_size",    s32_size,  0);
    checkOutput("sb_c1_wstrb",   s32_wstrb, 4'b1000);
    checkOutput("sb_c1_wdata",   s32_wdata, 32'hABAB_ABAB);
    checkOutput("sb_c1_wstrb64", s64_wstrb, 8'h08);
    checkOutput("sb_c1_wdata64", s64_wdata, 64'hABAB_ABAB_ABAB_ABAB);
    applyStimulus(1'b1, OP_SB, 32'h0000_0003, 32'h0000_00AB, 1'b0, 1'b1, 1'b1);
    checkOutput("sb_c2_stall", s32_stall, 1);
    checkOutput("sb_c2_done",  s32_done,  0);
    applyStimulus(1'b1, OP_SB, 32'h0000_0003, 32'h0000_00AB, 1'b0, 1'b1, 1'b1);
    checkOutput("sb_c3_done",  s32_done,  1);
    checkOutput("sb_c3_stall", s32_stall, 0);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // LH then LHU at 0x02 with data 0x8001_0000
    $display("[TB] LH / LHU sign and zero extension");
    rdata32 = 32'h8001_0000;
    rdata64 = 64'h0000_0000_8001_0000;
    applyStimulus(1'b1, OP_LH, 32'h0000_0002, 32'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, OP_LH, 32'h0000_0002, 32'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("lh_c1_size",  s32_size,  1);
    checkOutput("lh_c1_wstrb", s32_wstrb, 4'b0000);
    applyStimulus(1'b1, OP_LH, 32'h0000_0002, 32'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, OP_LH, 32'h0000_0002, 32'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("lh_done",    s32_done,  1);
    checkOutput("lh_rdata",   s32_rdata, 32'hFFFF_8001);
    checkOutput("lh_rdata64", s64_rdata, 32'hFFFF_8001);
    applyStimulus(1'b1, OP_LHU, 32'h0000_0002, 32'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, OP_LHU, 32'h0000_0002, 32'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, OP_LHU, 32'h0000_0002, 32'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, OP_LHU, 32'h0000_0002, 32'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("lhu_done",  s32_done,  1);
    checkOutput("lhu_rdata", s32_rdata, 32'h0000_8001);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // LB at 0x01 with one extra data_ok wait cycle
    $display("[TB] LB with delayed data_ok");
    rdata32 = 32'h0000_F000;
    rdata64 = 64'h0000_0000_0000_F000;
    applyStimulus(1'b1, OP_LB, 32'h0000_0001, 32'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_LB, 32'h0000_0001, 32'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_LB, 32'h0000_0001, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("lbw_c2_done", s32_done, 0);
    applyStimulus(1'b1, OP_LB, 32'h0000_0001, 32'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("lbw_c3_done",  s32_done,  0);
    checkOutput("lbw_c3_stall", s32_stall, 1);
    applyStimulus(1'b1, OP_LB, 32'h0000_0001, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("lbw_c4_done",    s32_done,  1);
    checkOutput("lbw_c4_rdata",   s32_rdata, 32'hFFFF_FFF0);
    checkOutput("lbw_c4_rdata64", s64_rdata, 32'hFFFF_FFF0);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Misaligned accesses and a non-memory opcode
    $display("[TB] Alignment exceptions");
    applyStimulus(1'b1, OP_SW, 32'h0000_0002, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
    checkOutput("sw_err_st",  s32_err_st, 1);
    checkOutput("sw_err_ld",  s32_err_ld, 0);
    checkOutput("sw_badva",   s32_badva,  32'h0000_0002);
    checkOutput("sw_stall",   s32_stall,  0);
    checkOutput("sw_req",     s32_req,    0);
    applyStimulus(1'b1, OP_SW, 32'h0000_0002, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
    checkOutput("sw_req_next", s64_req, 0);
    applyStimulus(1'b1, OP_LH, 32'h0000_0011, 32'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("lh_mis_err_ld", s64_err_ld, 1);
    checkOutput("lh_mis_badva",  s64_badva,  32'h0000_0011);
    applyStimulus(1'b1, 6'b001111, 32'h0000_0003, 32'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("nonmem_stall", s32_stall,  0);
    checkOutput("nonmem_errs",  {s32_err_ld, s32_err_st}, 2'b00);
    checkOutput("nonmem_badva", s32_badva,  0);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("nonmem_req", s32_req, 0);

    // LB held in REQ three cycles, then flushed
    $display("[TB] Flush in REQ");
    applyStimulus(1'b1, OP_LB, 32'h0000_0005, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("fr_c0_stall", s32_stall, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, OP_LB, 32'h0000_0005, 32'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("fr_hold_req", s32_req, 1);
    end
    applyStimulus(1'b1, OP_LB, 32'h0000_0005, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("fr_flush_stall", s32_stall, 1);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("fr_after_req",   s32_req,   0);
    checkOutput("fr_after_stall", s32_stall, 0);
    checkOutput("fr_after_done",  s32_done,  0);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("fr_after_done2", s32_done, 0);

    // LB flushed in WAIT; the late data_ok is drained silently
    $display("[TB] Flush in WAIT");
    applyStimulus(1'b1, OP_LB, 32'h0000_0005, 32'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_LB, 32'h0000_0005, 32'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_LB, 32'h0000_0005, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("fw_flush_stall", s64_stall, 1);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("fw_drain_stall", s64_stall, 1);
    checkOutput("fw_drain_req",   s64_req,   0);
    checkOutput("fw_drain_done",  s64_done,  0);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("fw_dok_stall", s64_stall, 1);
    checkOutput("fw_dok_done",  s64_done,  0);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("fw_idle_stall", s64_stall, 0);
    checkOutput("fw_idle_done",  s64_done,  0);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("fw_idle_done2", s64_done, 0);

    // Reset asserted while waiting for data
    $display("[TB] Reset in WAIT");
    rdata64 = 64'h8765_4321_1234_5678;
    applyStimulus(1'b1, OP_LW, 32'h1000_0004, 32'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_LW, 32'h1000_0004, 32'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_LW, 32'h1000_0004, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("rw_wait_stall", s64_stall, 1);
    resetn = 1'b0;
    #1;
    checkOutput("rw_rst_stall", s64_stall, 0);
    checkOutput("rw_rst_req",   s64_req,   0);
    checkOutput("rw_rst_done",  s64_done,  0);
    checkOutput("rw_rst_rdata", s64_rdata, 0);
    checkOutput("rw_rst_addr",  s64_addr,  0);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("rw_dok_done", s64_done, 0);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("rw_post_done",  s64_done,  0);
    checkOutput("rw_post_stall", s64_stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fails);
    $finish;
  end

endmodule

// File: doc/lsu_sram_bridge.md
# lsu_sram_bridge

Parametrised M-stage load/store unit that replaces purely combinational byte-lane steering with a handshaked SRAM-like data port. It decodes MIPS load/store opcodes, checks alignment, issues one request per memory instruction, stalls the pipeline until the response returns, and sign- or zero-extends load data. It supports data buses of 32 or 64 bits and handles pipeline flushes while a request is in flight.

## Interface
- DATA_W, 32, data bus width in bits; legal values are 32 and 64.
- ADDR_W, 32, address width.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_valid_i  in  1  a memory instruction is present in M; held until stall_o is low.
- op_i  in  6  opcode: LB=100000, LH=100001, LW=100011, LBU=100100, LHU=100101, SB=101000, SH=101001, SW=101011. Any other value is not a memory op.
- addr_i  in  ADDR_W  virtual address.
- wdata_i  in  32  store source (rt).
- flush_i  in  1  exception or eret flush from WB/CP0.
- stall_o  out  1  freezes M and the stages before it.
- done_o  out  1  one-cycle pulse; the access has completed.
- rdata_o  out  32  extended load result; valid while done_o is high.
- addr_err_load_o / addr_err_store_o  out  1  combinational alignment exceptions (AdEL/AdES).
- badvaddr_o  out  ADDR_W  equals addr_i when either error is asserted, otherwise 0.
- data_req_o  out  1  request valid.
- data_wr_o  out  1  1 = store.
- data_size_o  out  2  0 = byte, 1 = half, 2 = word.
- data_addr_o  out  ADDR_W  request address.
- data_wstrb_o  out  DATA_W/8  byte-lane write strobes.
- data_wdata_o  out  DATA_W  replicated store data.
- data_addr_ok_i  in  1  request accepted.
- data_data_ok_i  in  1  response or write acknowledge.
- data_rdata_i  in  DATA_W  read data.

## Operation
- Lane offset is off = addr_i[log2(DATA_W/8)-1:0].
- Alignment: LW/SW is misaligned when addr[1:0] != 0. LH/LHU/SH is misaligned when addr[0] != 0.
- A misaligned op asserts the matching error output. It issues no request and does not stall.
- Strobes: the base mask is 0001 (byte), 0011 (half) or 1111 (word), shifted left by off within DATA_W/8 lanes. Loads drive an all-zero strobe.
- Write data: store data is replicated across the whole bus: the byte DATA_W/8 times, the half DATA_W/16 times, or the word DATA_W/32 times.
- Load extension: the selected byte or half at lane off is sign-extended for LB/LH and zero-extended for LBU/LHU. LW takes the 32 bits at byte offset off.
- States:
  - IDLE: on a legal op with no flush_i, capture op, addr, strobe, wdata and off, then go to REQ.
  - REQ: data_req_o=1 with all request fields stable. If flush_i arrives before data_addr_ok_i, go to IDLE with no response. On data_addr_ok_i, go to WAIT.
  - WAIT: on data_data_ok_i, register the extended rdata and go to RESP. If flush_i arrives, go to DRAIN.
  - DRAIN: on data_data_ok_i, discard the data and go to IDLE; done_o is never asserted.
  - RESP: done_o=1 (masked by flush_i). Go to IDLE next cycle.
- stall_o = mem_valid_i & legal_op & ~flush_i & (state != RESP). It is also 1 in REQ, WAIT and DRAIN regardless of mem_valid_i.
- If flush_i and data_addr_ok_i arrive in the same REQ cycle, the request counts as accepted. Go to DRAIN.
- At most one outstanding request. data_data_ok_i is never sampled outside WAIT and DRAIN.
- Non-memory opcodes: no request, no stall, no errors.

## Timing
- Reset values: state IDLE; all outputs 0, including data_req_o, done_o, stall_o, rdata_o and strobes.
- A reset mid-transaction aborts to IDLE. Responses arriving after reset are ignored.
- Minimum legal access latency is 4 cycles:
  - cycle 0: IDLE, stall_o=1.
  - cycle 1: REQ, data_addr_ok_i sampled.
  - cycle 2: WAIT, data_data_ok_i sampled.
  - cycle 3: RESP, done_o=1, stall_o=0, the pipeline advances.
- Each extra wait cycle on addr_ok or data_ok adds exactly one cycle.
- Request fields change only on the IDLE to REQ transition.
- Error outputs are combinational from op_i and addr_i in the same cycle. They have zero latency.

## Test plan
- LW at 0x1000_0004 with DATA_W=64, addr_ok/data_ok immediate, rdata=0x8765_4321_1234_5678 -> request with wstrb=0x00 and size=2; done_o in cycle 3 with rdata_o=0x8765_4321.
- SB at 0x...03, wdata=0x0000_00AB, DATA_W=32 -> wstrb=1000, wdata=0xABAB_ABAB, wr=1; done after data_ok; stall_o low in RESP only.
- LH at 0x...02, data=0x8001_0000 -> rdata_o=0xFFFF_8001. The same access as LHU -> rdata_o=0x0000_8001.
- SW at 0x...02 -> addr_err_store_o=1 and badvaddr_o=addr in the same cycle; data_req_o stays 0; stall_o=0.
- LB with addr_ok held low 3 cycles, then flush_i -> req drops, IDLE, no done. A second run flushes in WAIT -> DRAIN absorbs the late data_ok=1 without done_o.
- Assert resetn=0 while in WAIT -> all outputs 0 immediately; a data_ok pulse after release produces no done_o.
